// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//   Raster sequencer for the 640x480@60 VGA path (25 MHz pixel clock).
//   Owns the horizontal/vertical position counters and a run/stop FSM that
//   starts and stops scanning only on frame boundaries. It decodes the porch
//   and sync phases into registered hsync/vsync/video_on. It also produces the
//   end-of-line strobe (enable_V_Counter) and the frame_start strobe.
//
// Ports
//   clk_25Mhz         in   pixel clock, the only clock of the block
//   reset             in   asynchronous, active-high reset
//   run_req           in   level request: 1 = scan, 0 = stop at end of frame
//   running           out  1 while the FSM is in RUN or STOPPING
//   H_Count_Value     out  current pixel column, 0..H_TOTAL-1
//   V_Count_Value     out  current line, 0..V_TOTAL-1
//   enable_V_Counter  out  1 on the last pixel of every line
//   frame_start       out  1 on the cycle showing H=0, V=0 while running
//   hsync / vsync     out  SYNC_POL during the sync phase, ~SYNC_POL otherwise
//   video_on          out  1 inside the visible window
//
// Handshake: run_req is a plain level sampled on every rising clock edge.
// There is no ready/acknowledge. The request is honoured on the next edge
// when idle. A stop request only takes effect on the last pixel of the frame.
// -----------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk_25Mhz,
    input  logic        reset,
    input  logic        run_req,
    output logic        running,
    output logic [15:0] H_Count_Value,
    output logic [15:0] V_Count_Value,
    output logic        enable_V_Counter,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Phase boundaries fixed at elaboration time, sized to the counters.
    localparam logic [15:0] H_LAST       = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS_END    = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS_END    = 16'(V_ACTIVE);
    localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] V_SYNC_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_q, video_d;
    logic        eol_q, eol_d;
    logic        fs_q, fs_d;

    logic        line_end;
    logic        frame_end;
    logic [15:0] h_step;
    logic [15:0] v_step;
    logic        scan_d;

    // Free-running raster step, used by both scanning states.
    always_comb begin
        line_end  = (h_q == H_LAST);
        frame_end = line_end && (v_q == V_LAST);
        h_step    = line_end ? 16'd0 : h_q + 16'd1;
        if (line_end) begin
            v_step = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
        end else begin
            v_step = v_q;
        end
    end

    // Next state and next counts.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                h_d = 16'd0;
                v_d = 16'd0;
                if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                h_d = h_step;
                v_d = v_step;
                if (!run_req) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                // A renewed request wins over the stop, so a short drop of
                // run_req never ends the scan.
                if (run_req) begin
                    state_d = ST_RUN;
                    h_d     = h_step;
                    v_d     = v_step;
                end else if (frame_end) begin
                    state_d = ST_IDLE;
                    h_d     = 16'd0;
                    v_d     = 16'd0;
                end else begin
                    h_d = h_step;
                    v_d = v_step;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = 16'd0;
                v_d     = 16'd0;
            end
        endcase
    end

    // Output decode on the next-count values. The registered outputs then line
    // up with the counts they describe, with no extra pipeline stage.
    always_comb begin
        scan_d  = (state_d != ST_IDLE);
        hsync_d = ~SYNC_POL;
        vsync_d = ~SYNC_POL;
        video_d = 1'b0;
        eol_d   = 1'b0;
        fs_d    = 1'b0;
        if (scan_d) begin
            if (h_d >= H_SYNC_START && h_d < H_SYNC_END) begin
                hsync_d = SYNC_POL;
            end
            if (v_d >= V_SYNC_START && v_d < V_SYNC_END) begin
                vsync_d = SYNC_POL;
            end
            video_d = (h_d < H_VIS_END) && (v_d < V_VIS_END);
            eol_d   = (h_d == H_LAST);
            fs_d    = (h_d == 16'd0) && (v_d == 16'd0);
        end
    end

    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            h_q     <= 16'd0;
            v_q     <= 16'd0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            video_q <= 1'b0;
            eol_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            eol_q   <= eol_d;
            fs_q    <= fs_d;
        end
    end

    assign running          = (state_q != ST_IDLE);
    assign H_Count_Value    = h_q;
    assign V_Count_Value    = v_q;
    assign hsync            = hsync_q;
    assign vsync            = vsync_q;
    assign video_on         = video_q;
    assign enable_V_Counter = eol_q;
    assign frame_start      = fs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   Two instances share clock, reset and run_req. Instance 0 uses the
//   640x480 defaults and instance 1 a reduced 25x17 raster, so whole frames
//   fit in a short run. The reference model tracks each raster as a single
//   position within the frame and derives H/V and every phase from it.
// -----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run_req = 1'b0;
    always #20 clk = ~clk;

    // Reduced raster for instance 1
    localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
    localparam int S_VA = 10, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_FRAME = (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP);

    logic        a_running, a_eol, a_fs, a_hs, a_vs, a_vo;
    logic [15:0] a_h, a_v;
    logic        b_running, b_eol, b_fs, b_hs, b_vs, b_vo;
    logic [15:0] b_h, b_v;

    vga_timing_ctrl dut_a (
        .clk_25Mhz(clk), .reset(reset), .run_req(run_req),
        .running(a_running), .H_Count_Value(a_h), .V_Count_Value(a_v),
        .enable_V_Counter(a_eol), .frame_start(a_fs),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vo)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .SYNC_POL(1'b0)
    ) dut_b (
        .clk_25Mhz(clk), .reset(reset), .run_req(run_req),
        .running(b_running), .H_Count_Value(b_h), .V_Count_Value(b_v),
        .enable_V_Counter(b_eol), .frame_start(b_fs),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vo)
    );

    // Reference model: geometry per instance plus frame position
    int cfg_ha[2], cfg_hfp[2], cfg_hs[2], cfg_ht[2];
    int cfg_va[2], cfg_vfp[2], cfg_vs[2], cfg_vt[2];
    bit m_scan[2];
    bit m_arm[2];
    int m_pos[2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_scan[i] = 1'b0;
            m_arm[i]  = 1'b0;
            m_pos[i]  = 0;
        end
    endtask

    // One clock of the model. The stop request is "armed" whenever run_req
    // was low at the previous edge. An armed scan ends after the last pixel.
    task automatic model_step(input int i, input bit req);
        int total;
        total = cfg_ht[i] * cfg_vt[i];
        if (!m_scan[i]) begin
            if (req) begin
                m_scan[i] = 1'b1;
                m_pos[i]  = 0;
                m_arm[i]  = 1'b0;
            end
        end else begin
            if (m_arm[i] && !req && m_pos[i] == total - 1) begin
                m_scan[i] = 1'b0;
                m_pos[i]  = 0;
            end else begin
                m_pos[i] = (m_pos[i] + 1) % total;
            end
            m_arm[i] = !req;
        end
    endtask

    task automatic check_inst(input int i, input logic run_o, input logic [15:0] h_o,
                              input logic [15:0] v_o, input logic eol_o, input logic fs_o,
                              input logic hs_o, input logic vs_o, input logic vo_o);
        int h, v;
        logic e_hs, e_vs, e_vo, e_eol, e_fs;
        h = m_scan[i] ? m_pos[i] % cfg_ht[i] : 0;
        v = m_scan[i] ? m_pos[i] / cfg_ht[i] : 0;
        e_hs  = !(m_scan[i] && h >= cfg_ha[i] + cfg_hfp[i] && h < cfg_ha[i] + cfg_hfp[i] + cfg_hs[i]);
        e_vs  = !(m_scan[i] && v >= cfg_va[i] + cfg_vfp[i] && v < cfg_va[i] + cfg_vfp[i] + cfg_vs[i]);
        e_vo  = m_scan[i] && h < cfg_ha[i] && v < cfg_va[i];
        e_eol = m_scan[i] && h == cfg_ht[i] - 1;
        e_fs  = m_scan[i] && m_pos[i] == 0;
        chk($sformatf("i%0d_running", i), {15'd0, run_o}, {15'd0, m_scan[i]});
        chk($sformatf("i%0d_h", i), h_o, 16'(h));
        chk($sformatf("i%0d_v", i), v_o, 16'(v));
        chk($sformatf("i%0d_eol", i), {15'd0, eol_o}, {15'd0, e_eol});
        chk($sformatf("i%0d_frame_start", i), {15'd0, fs_o}, {15'd0, e_fs});
        chk($sformatf("i%0d_hsync", i), {15'd0, hs_o}, {15'd0, e_hs});
        chk($sformatf("i%0d_vsync", i), {15'd0, vs_o}, {15'd0, e_vs});
        chk($sformatf("i%0d_video_on", i), {15'd0, vo_o}, {15'd0, e_vo});
    endtask

    task automatic check_all();
        check_inst(0, a_running, a_h, a_v, a_eol, a_fs, a_hs, a_vs, a_vo);
        check_inst(1, b_running, b_h, b_v, b_eol, b_fs, b_hs, b_vs, b_vo);
    endtask

    // Driver: one clock, model update at the edge, checks on the falling edge
    task automatic tick();
        bit req;
        req = run_req;
        @(posedge clk);
        model_step(0, req);
        model_step(1, req);
        @(negedge clk);
        check_all();
    endtask

    // Reset raised between edges; outputs must clear in the same cycle
    task automatic async_reset();
        @(negedge clk);
        #5 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    task automatic run_until_pos(input int i, input int pos, input int budget);
        int n;
        n = 0;
        while (!(m_scan[i] && m_pos[i] == pos) && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("reach_pos_i%0d_%0d", i, pos), {15'd0, (m_scan[i] && m_pos[i] == pos)}, 16'd1);
    endtask

    // Counts cycles with instance 1 running until it stops, bounded
    task automatic count_until_stop(inout int cnt);
        int n;
        n = 0;
        while (m_scan[1] && n < 3 * S_FRAME) begin
            tick();
            if (b_running) cnt++;
            n++;
        end
        chk("stop_reached", {15'd0, m_scan[1]}, 16'd0);
    endtask

    initial begin
        int cnt;
        cfg_ha[0] = 640; cfg_hfp[0] = 16; cfg_hs[0] = 96; cfg_ht[0] = 800;
        cfg_va[0] = 480; cfg_vfp[0] = 10; cfg_vs[0] = 2;  cfg_vt[0] = 525;
        cfg_ha[1] = S_HA; cfg_hfp[1] = S_HFP; cfg_hs[1] = S_HS; cfg_ht[1] = S_HA + S_HFP + S_HS + S_HBP;
        cfg_va[1] = S_VA; cfg_vfp[1] = S_VFP; cfg_vs[1] = S_VS; cfg_vt[1] = S_VA + S_VFP + S_VS + S_VBP;
        model_reset();

        // Power-on reset, then idle stays static with run_req low
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;
        repeat (5) tick();

        // Start, then scan several small frames and part of a default frame
        run_req = 1'b1;
        tick();
        chk("first_frame_start", {15'd0, b_fs}, 16'd1);
        run_until_pos(0, 2 * 800 + 300, 3000);

        // Mid-frame reset, then idle holds with run_req low
        run_req = 1'b0;
        async_reset();
        repeat (5) tick();

        // One-cycle run_req pulse scans exactly one full frame
        run_req = 1'b1;
        tick();
        cnt = b_running ? 1 : 0;
        run_req = 1'b0;
        count_until_stop(cnt);
        chk("pulse_frame_cycles", 16'(cnt), 16'(S_FRAME));
        async_reset();

        // Drop run_req mid-frame: the frame still completes in full
        run_req = 1'b1;
        tick();
        cnt = 1;
        while (!(m_pos[1] == 5 * cfg_ht[1] + 10) && cnt < 2 * S_FRAME) begin
            tick();
            cnt++;
        end
        run_req = 1'b0;
        count_until_stop(cnt);
        chk("drop_frame_cycles", 16'(cnt), 16'(S_FRAME));
        repeat (3) tick();
        async_reset();

        // Stop then resume: counting continues through the wrap
        run_req = 1'b1;
        tick();
        run_until_pos(1, 3 * cfg_ht[1], 2 * S_FRAME);
        run_req = 1'b0;
        run_until_pos(1, 8 * cfg_ht[1], 2 * S_FRAME);
        run_req = 1'b1;
        repeat (S_FRAME + 20) tick();
        chk("resume_still_running", {15'd0, b_running}, 16'd1);
        async_reset();

        // Randomized run_req with occasional asynchronous resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 4) run_req = ~run_req;
            if ($urandom_range(0, 999) == 0) async_reset();
            else tick();
        end
        run_req = 1'b0;
        async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
